div_job_sequencer: RTL and testbench
====================================

DIV_JOB_SEQUENCER -- requirements
Module: div_job_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of operand, result and data-memory data.
REQ-002 Parameter ADDR_W, default 8, SHALL set the data-memory address width.
REQ-003 Parameter TIMEOUT, default 4095, SHALL set the maximum cycles spent in WAIT before abort.
REQ-004 The ports SHALL be (name, direction, width, meaning):
 clk  in  1  single clock; all logic rising-edge.
 reset  in  1  synchronous, active-high reset.
 job_valid  in  1  host offers a division job.
 job_ready  out  1  sequencer accepts a job (IDLE only).
 job_dividend  in  DATA_W  dividend operand.
 job_divisor  in  DATA_W  divisor operand.
 res_valid  out  1  result available.
 res_ready  in  1  host consumes the result.
 res_quot  out  DATA_W  quotient.
 res_rem  out  DATA_W  remainder.
 res_timeout  out  1  result produced by timeout abort.
 cpu_start  out  1  launch pulse to the CPU start input.
 cpu_ack  in  1  CPU "program run complete".
 dm_host_sel  out  1  1 = sequencer owns the data-memory port; 0 = CPU owns it.
 dm_we  out  1  data-memory write enable.
 dm_addr  out  ADDR_W  data-memory address.
 dm_wdata  out  DATA_W  data-memory write data.
 dm_rdata  in  DATA_W  data-memory read data, valid one cycle after dm_addr (registered read).

Function
REQ-005 States SHALL be IDLE, WR_DVD, WR_DVS, START, WAIT, RD_Q, RD_R, CAPT, RESP.
REQ-006 A job is accepted when job_valid && job_ready; operands SHALL be latched in that cycle.
REQ-007 Accepted job with divisor 0 SHALL skip the CPU: next state RESP with res_quot=all-ones, res_rem=dividend, res_timeout=0, no cpu_start.
REQ-008 Otherwise IDLE->WR_DVD: dm_we=1, dm_addr=0, dm_wdata=dividend.
REQ-009 WR_DVD->WR_DVS: dm_we=1, dm_addr=2, dm_wdata=divisor.
REQ-010 WR_DVS->START: cpu_start=1 for exactly this one cycle; dm_host_sel=0.
REQ-011 START->WAIT: dm_host_sel=0; cycle counter cleared on entry, incremented each WAIT cycle.
REQ-012 In WAIT, cpu_ack=1 SHALL move to RD_Q next cycle; cpu_ack in any other state SHALL be ignored.
REQ-013 In WAIT, counter reaching TIMEOUT-1 without ack SHALL move to RESP with res_quot=res_rem=all-ones, res_timeout=1; ack and timeout in the same cycle SHALL favour ack.
REQ-014 RD_Q: dm_addr=4; RD_R: dm_addr=5, res_quot<=dm_rdata; CAPT: res_rem<=dm_rdata; CAPT->RESP.
REQ-015 dm_host_sel SHALL be 1 in IDLE, WR_DVD, WR_DVS, RD_Q, RD_R, CAPT, RESP; dm_we SHALL be 0 outside WR_DVD/WR_DVS.
REQ-016 RESP: res_valid=1, results held stable until res_ready=1; then return to IDLE next cycle.
REQ-017 job_ready SHALL be 1 only in IDLE; no new job accepted in the cycle res_valid&&res_ready.
REQ-018 Latency: accept at cycle 0, cpu_start at cycle 3, ack seen at WAIT cycle k gives res_valid at k+4.

Reset
REQ-019 reset SHALL force IDLE in the next cycle from any state, including mid-WAIT, discarding the job.
REQ-020 Reset values: job_ready=1 (after reset), res_valid=0, res_quot=0, res_rem=0, res_timeout=0, cpu_start=0, dm_host_sel=1, dm_we=0, dm_addr=0, dm_wdata=0, counter=0.

Structure
REQ-021 Package div_seq_pkg SHALL hold state encoding and address constants DVD_ADDR=0, DVS_ADDR=2, QUOT_ADDR=4, REM_ADDR=5.
REQ-022 Timeout counter SHALL be sub-module seq_timer (clear, enable, expired).

Verification
REQ-023 Job 4/2, CPU model acks after 50 cycles -> DM[0]=4, DM[2]=2, one cpu_start pulse, res_quot=2, res_rem=0, res_timeout=0.
REQ-024 Job 200/7 -> res_quot=28, res_rem=4; res_valid exactly 4 cycles after ack cycle.
REQ-025 Job 9/0 -> no dm write, no cpu_start, res_quot=0xFF, res_rem=9, res_valid at cycle 1.
REQ-026 TIMEOUT=16, ack never asserted -> res_timeout=1, res_quot=res_rem=0xFF after 16 WAIT cycles.
REQ-027 res_ready low 5 cycles in RESP -> res_valid and results held; job_valid ignored until handshake.
REQ-028 reset pulsed mid-WAIT -> IDLE next cycle, all outputs at reset values; following 4/2 job completes correctly.

Source files
------------

// File: rtl/div_job_sequencer_pkg.sv
// div_seq_pkg: state encoding and data-memory mailbox addresses for the division sequencer
package div_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_DVD, S_WR_DVS, S_START, S_WAIT, S_RD_Q, S_RD_R, S_CAPT, S_RESP
  } seq_state_t;
  localparam int DVD_ADDR  = 0;
  localparam int DVS_ADDR  = 2;
  localparam int QUOT_ADDR = 4;
  localparam int REM_ADDR  = 5;
endpackage

// File: rtl/div_job_sequencer_if.sv
// div_job_sequencer_if: host job/result handshakes plus CPU launch and data-memory port
interface div_job_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              job_valid;
  logic              job_ready;
  logic [DATA_W-1:0] job_dividend;
  logic [DATA_W-1:0] job_divisor;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_quot;
  logic [DATA_W-1:0] res_rem;
  logic              res_timeout;
  logic              cpu_start;
  logic              cpu_ack;
  logic              dm_host_sel;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  modport master (
    output job_valid, job_dividend, job_divisor, res_ready, cpu_ack, dm_rdata,
    input  job_ready, res_valid, res_quot, res_rem, res_timeout, cpu_start,
           dm_host_sel, dm_we, dm_addr, dm_wdata
  );
  modport slave (
    input  job_valid, job_dividend, job_divisor, res_ready, cpu_ack, dm_rdata,
    output job_ready, res_valid, res_quot, res_rem, res_timeout, cpu_start,
           dm_host_sel, dm_we, dm_addr, dm_wdata
  );
endinterface

// File: rtl/div_job_sequencer_timer.sv
// seq_timer: WAIT-state cycle counter, held at zero while cleared
module seq_timer #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || clear) ? '0 : enable ? cnt + 1'b1 : cnt;
  assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/div_job_sequencer.sv
// div_job_sequencer: hands a division job to a CPU via data memory and returns its result
module div_job_sequencer
  import div_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4095
) (
  input logic             clk,
  input logic             reset,
  div_job_sequencer_if.slave bus
);
  seq_state_t        state, state_nx;
  logic [DATA_W-1:0] dvd, dvs, quot, rem;
  logic              tmo, expired, accept;
  assign accept = state == S_IDLE && bus.job_valid;
  seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk,
    .reset,
    .clear  (state != S_WAIT),
    .enable (state == S_WAIT),
    .expired
  );
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = !bus.job_valid ? S_IDLE : bus.job_divisor == '0 ? S_RESP : S_WR_DVD;
      S_WR_DVD: state_nx = S_WR_DVS;
      S_WR_DVS: state_nx = S_START;
      S_START:  state_nx = S_WAIT;
      S_WAIT:   state_nx = bus.cpu_ack ? S_RD_Q : expired ? S_RESP : S_WAIT;
      S_RD_Q:   state_nx = S_RD_R;
      S_RD_R:   state_nx = S_CAPT;
      S_CAPT:   state_nx = S_RESP;
      S_RESP:   state_nx = bus.res_ready ? S_IDLE : S_RESP;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    bus.job_ready   = state == S_IDLE;
    bus.res_valid   = state == S_RESP;
    bus.cpu_start   = state == S_START;
    bus.dm_host_sel = !(state == S_START || state == S_WAIT);
    bus.dm_we       = state == S_WR_DVD || state == S_WR_DVS;
    bus.dm_addr     = state == S_WR_DVS ? ADDR_W'(DVS_ADDR) :
                      state == S_RD_Q   ? ADDR_W'(QUOT_ADDR) :
                      state == S_RD_R   ? ADDR_W'(REM_ADDR) : ADDR_W'(DVD_ADDR);
    bus.dm_wdata    = state == S_WR_DVD ? dvd : state == S_WR_DVS ? dvs : '0;
    bus.res_quot    = quot;
    bus.res_rem     = rem;
    bus.res_timeout = tmo;
  end
  // Registered read: RD_R sees the quotient addressed in RD_Q, CAPT the remainder
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd  <= '0;
      dvs  <= '0;
      quot <= '0;
      rem  <= '0;
      tmo  <= 1'b0;
    end else begin
      if (accept) begin
        dvd <= bus.job_dividend;
        dvs <= bus.job_divisor;
        tmo <= 1'b0;
        if (bus.job_divisor == '0) begin
          quot <= '1;
          rem  <= bus.job_dividend;
        end
      end
      if (state == S_WAIT && !bus.cpu_ack && expired) begin
        quot <= '1;
        rem  <= '1;
        tmo  <= 1'b1;
      end
      if (state == S_RD_R) quot <= bus.dm_rdata;
      if (state == S_CAPT) rem <= bus.dm_rdata;
    end
  end
endmodule

// File: tb/tb_div_job_sequencer.sv
// tb_div_job_sequencer: directed tests with a data-memory/CPU model on the main instance
module tb_div_job_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_job_sequencer_if #(.DATA_W(8), .ADDR_W(8)) bus ();
  div_job_sequencer_if #(.DATA_W(8), .ADDR_W(8)) bus2 ();
  div_job_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));
  div_job_sequencer #(.TIMEOUT(16)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  int total = 0;
  int bad = 0;
  logic [7:0] mem [256];
  int cyc = 0, ack_cyc = 0, start_cyc = 0, n_start = 0, n_wr = 0, cpu_cnt = 0;
  int ack_delay = 50;
  logic cpu_busy = 1'b0;

  // Data memory with registered read, plus a CPU that acks ack_delay cycles after start
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.dm_rdata <= mem[bus.dm_addr];
    bus.cpu_ack <= 1'b0;
    if (bus.cpu_start) begin n_start <= n_start + 1; start_cyc <= cyc; end
    if (bus.dm_host_sel && bus.dm_we) begin n_wr <= n_wr + 1; mem[bus.dm_addr] <= bus.dm_wdata; end
    if (bus.cpu_ack) ack_cyc <= cyc;
    if (reset) begin
      cpu_busy <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.cpu_start) begin
      cpu_busy <= 1'b1;
      cpu_cnt <= 0;
    end else if (cpu_busy) begin
      if (cpu_cnt == ack_delay - 1) begin
        mem[4] <= mem[2] != 0 ? mem[0] / mem[2] : 8'hFF;
        mem[5] <= mem[2] != 0 ? mem[0] % mem[2] : 8'hFF;
        bus.cpu_ack <= 1'b1;
        cpu_busy <= 1'b0;
      end else cpu_cnt <= cpu_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b, output int acc);
    bus.job_dividend = a;
    bus.job_divisor = b;
    bus.job_valid = 1'b1;
    acc = cyc;
    tick();
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_res(input int acc, input int limit, output int lat);
    while (!bus.res_valid && cyc - acc < limit) tick();
    lat = bus.res_valid ? cyc - acc : -1;
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if ({bus.job_ready, bus.res_valid, bus.res_timeout, bus.cpu_start, bus.dm_host_sel, bus.dm_we} !== 6'b100010) begin bad++; $display("FAIL reset_flags: got %b want 100010", {bus.job_ready, bus.res_valid, bus.res_timeout, bus.cpu_start, bus.dm_host_sel, bus.dm_we}); end
    total++; if ({bus.res_quot, bus.res_rem} !== 16'h0000) begin bad++; $display("FAIL reset_results: got %h want 0000", {bus.res_quot, bus.res_rem}); end
    total++; if ({bus.dm_addr, bus.dm_wdata} !== 16'h0000) begin bad++; $display("FAIL reset_dm: got %h want 0000", {bus.dm_addr, bus.dm_wdata}); end
    reset = 1'b0;
    tick();
    total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL reset_idle_ready: got %b want 1", bus.job_ready); end
  endtask

  task automatic test_basic();
    int acc, lat, s0, w0;
    ack_delay = 50;
    s0 = n_start;
    w0 = n_wr;
    offer(8'd4, 8'd2, acc);
    wait_res(acc, 100, lat);
    total++; if (lat !== 58) begin bad++; $display("FAIL basic_latency: got %0d want 58", lat); end
    total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL basic_start_count: got %0d want 1", n_start - s0); end
    total++; if (start_cyc - acc !== 3) begin bad++; $display("FAIL basic_start_cycle: got %0d want 3", start_cyc - acc); end
    total++; if (n_wr - w0 !== 2) begin bad++; $display("FAIL basic_dm_writes: got %0d want 2", n_wr - w0); end
    total++; if ({mem[0], mem[2]} !== 16'h0402) begin bad++; $display("FAIL basic_dm_contents: got %h want 0402", {mem[0], mem[2]}); end
    total++; if ({bus.res_quot, bus.res_rem, bus.res_timeout} !== {8'd2, 8'd0, 1'b0}) begin bad++; $display("FAIL basic_result: got q=%0d r=%0d t=%b want q=2 r=0 t=0", bus.res_quot, bus.res_rem, bus.res_timeout); end
    handshake();
    total++; if ({bus.res_valid, bus.job_ready} !== 2'b01) begin bad++; $display("FAIL basic_return_idle: got %b want 01", {bus.res_valid, bus.job_ready}); end
  endtask

  task automatic test_ack_latency();
    int acc, lat;
    ack_delay = 10;
    offer(8'd200, 8'd7, acc);
    wait_res(acc, 100, lat);
    total++; if (lat !== 18) begin bad++; $display("FAIL ack_latency: got %0d want 18", lat); end
    total++; if (cyc - ack_cyc !== 4) begin bad++; $display("FAIL ack_to_valid: got %0d want 4", cyc - ack_cyc); end
    total++; if ({bus.res_quot, bus.res_rem} !== {8'd28, 8'd4}) begin bad++; $display("FAIL ack_result: got q=%0d r=%0d want q=28 r=4", bus.res_quot, bus.res_rem); end
    handshake();
  endtask

  task automatic test_div0();
    int acc, lat, s0, w0;
    s0 = n_start;
    w0 = n_wr;
    offer(8'd9, 8'd0, acc);
    wait_res(acc, 5, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency: got %0d want 1", lat); end
    total++; if ({bus.res_quot, bus.res_rem, bus.res_timeout} !== {8'hFF, 8'd9, 1'b0}) begin bad++; $display("FAIL div0_result: got q=%h r=%0d t=%b want q=ff r=9 t=0", bus.res_quot, bus.res_rem, bus.res_timeout); end
    handshake();
    total++; if (n_start - s0 !== 0 || n_wr - w0 !== 0) begin bad++; $display("FAIL div0_no_activity: got starts=%0d writes=%0d want 0 0", n_start - s0, n_wr - w0); end
  endtask

  task automatic test_hold();
    int acc, lat;
    ack_delay = 3;
    offer(8'd15, 8'd4, acc);
    wait_res(acc, 50, lat);
    total++; if (lat !== 11) begin bad++; $display("FAIL hold_latency: got %0d want 11", lat); end
    bus.job_dividend = 8'd1;
    bus.job_divisor = 8'd1;
    bus.job_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({bus.res_valid, bus.job_ready, bus.res_quot, bus.res_rem} !== {1'b1, 1'b0, 8'd3, 8'd3}) begin bad++; $display("FAIL hold_cycle%0d: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=3 r=3", i, bus.res_valid, bus.job_ready, bus.res_quot, bus.res_rem); end
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.job_valid = 1'b0;
    total++; if ({bus.res_valid, bus.job_ready} !== 2'b01) begin bad++; $display("FAIL hold_no_accept_on_handshake: got %b want 01", {bus.res_valid, bus.job_ready}); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bus2.job_dividend = 8'd10;
    bus2.job_divisor = 8'd3;
    bus2.job_valid = 1'b1;
    tick();
    bus2.job_valid = 1'b0;
    n = 1;
    while (!bus2.res_valid && n < 40) begin tick(); n++; end
    total++; if (n !== 20) begin bad++; $display("FAIL timeout_latency: got %0d want 20", n); end
    total++; if ({bus2.res_quot, bus2.res_rem, bus2.res_timeout} !== {8'hFF, 8'hFF, 1'b1}) begin bad++; $display("FAIL timeout_result: got q=%h r=%h t=%b want q=ff r=ff t=1", bus2.res_quot, bus2.res_rem, bus2.res_timeout); end
    bus2.res_ready = 1'b1;
    tick();
    bus2.res_ready = 1'b0;
  endtask

  task automatic test_ack_vs_timeout();
    int n;
    bus2.job_dividend = 8'd10;
    bus2.job_divisor = 8'd3;
    bus2.job_valid = 1'b1;
    tick();
    bus2.job_valid = 1'b0;
    repeat (18) tick();
    total++; if (bus2.res_valid !== 1'b0) begin bad++; $display("FAIL tie_still_waiting: got %b want 0", bus2.res_valid); end
    bus2.cpu_ack = 1'b1;
    tick();
    bus2.cpu_ack = 1'b0;
    n = 20;
    while (!bus2.res_valid && n < 40) begin tick(); n++; end
    total++; if (n !== 23) begin bad++; $display("FAIL tie_latency: got %0d want 23", n); end
    total++; if ({bus2.res_quot, bus2.res_rem, bus2.res_timeout} !== {8'h5A, 8'h5A, 1'b0}) begin bad++; $display("FAIL tie_result: got q=%h r=%h t=%b want q=5a r=5a t=0", bus2.res_quot, bus2.res_rem, bus2.res_timeout); end
    bus2.res_ready = 1'b1;
    tick();
    bus2.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int acc, lat;
    ack_delay = 200;
    offer(8'd4, 8'd2, acc);
    repeat (9) tick();
    total++; if ({bus.cpu_start, bus.dm_host_sel, bus.job_ready} !== 3'b000) begin bad++; $display("FAIL midwait_in_wait: got %b want 000", {bus.cpu_start, bus.dm_host_sel, bus.job_ready}); end
    reset = 1'b1;
    tick();
    total++; if ({bus.job_ready, bus.res_valid, bus.res_timeout, bus.cpu_start, bus.dm_host_sel, bus.dm_we} !== 6'b100010) begin bad++; $display("FAIL midwait_flags: got %b want 100010", {bus.job_ready, bus.res_valid, bus.res_timeout, bus.cpu_start, bus.dm_host_sel, bus.dm_we}); end
    total++; if ({bus.res_quot, bus.res_rem, bus.dm_addr, bus.dm_wdata} !== 32'h0) begin bad++; $display("FAIL midwait_values: got %h want 00000000", {bus.res_quot, bus.res_rem, bus.dm_addr, bus.dm_wdata}); end
    reset = 1'b0;
    tick();
    ack_delay = 5;
    offer(8'd4, 8'd2, acc);
    wait_res(acc, 50, lat);
    total++; if (lat !== 13) begin bad++; $display("FAIL midwait_rerun_latency: got %0d want 13", lat); end
    total++; if ({bus.res_quot, bus.res_rem, bus.res_timeout} !== {8'd2, 8'd0, 1'b0}) begin bad++; $display("FAIL midwait_rerun_result: got q=%0d r=%0d t=%b want q=2 r=0 t=0", bus.res_quot, bus.res_rem, bus.res_timeout); end
    handshake();
  endtask

  initial begin
    bus.job_valid = 1'b0;
    bus.job_dividend = 8'd0;
    bus.job_divisor = 8'd0;
    bus.res_ready = 1'b0;
    bus2.job_valid = 1'b0;
    bus2.job_dividend = 8'd0;
    bus2.job_divisor = 8'd0;
    bus2.res_ready = 1'b0;
    bus2.cpu_ack = 1'b0;
    bus2.dm_rdata = 8'h5A;
    test_reset();
    test_basic();
    test_ack_latency();
    test_div0();
    test_hold();
    test_timeout();
    test_ack_vs_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
